dct_transpose_buf: RTL and testbench

// - Ping-pong 8x8 transpose buffer between the column-pass DCT collector and the row-pass 1-D DCT.
// - Accepts one 8-coefficient column vector per handshake; after 8 columns a block is complete.
// - Emits the same block as 8 row vectors, so row pass sees the transposed matrix.
// - Two banks: one fills while the other drains, for full-rate streaming.

---
 rtl/dct_pkg.sv | 15 +
 rtl/dct_tbuf_bank.sv | 33 +++
 rtl/dct_transpose_buf.sv | 104 ++++++++++
 tb/tb_dct_transpose_buf.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 DCT transpose datapath.
package dct_pkg;

    localparam int unsigned DCT_N     = 8;
    localparam int unsigned DCT_SIZE  = 16;
    localparam int unsigned DCT_IDX_W = 3;

    typedef logic signed [DCT_SIZE-1:0] coef_t;
    typedef coef_t coef_vec_t [DCT_N];

    function automatic logic is_last_idx(input logic [DCT_IDX_W-1:0] idx);
        return idx == DCT_IDX_W'(DCT_N - 1);
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One 8x8 coefficient bank: column-wide write port, row-wide combinational read port.
module dct_tbuf_bank
    import dct_pkg::*;
#(
    parameter int unsigned SIZE = DCT_SIZE
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DCT_IDX_W-1:0]  i_wr_col,
    input  logic [DCT_N*SIZE-1:0] i_wr_vec,
    input  logic [DCT_IDX_W-1:0]  i_rd_row,
    output logic [DCT_N*SIZE-1:0] o_rd_vec
);

    // r_mem[row][col]; contents are deliberately not reset.
    logic [SIZE-1:0] r_mem [DCT_N][DCT_N];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int r = 0; r < DCT_N; r++) begin
                r_mem[r][i_wr_col] <= i_wr_vec[r*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        o_rd_vec = '0;
        for (int c = 0; c < DCT_N; c++) begin
            o_rd_vec[c*SIZE +: SIZE] = r_mem[i_rd_row][c];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: columns in, rows out, one bank fills while the other drains.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int unsigned SIZE = DCT_SIZE,
    parameter int unsigned N    = DCT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [N*SIZE-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*SIZE-1:0] out_data,
    output logic [2:0]        out_row,
    output logic              out_last
);

    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [2:0] r_wr_col;
    logic [2:0] r_rd_row;
    logic [1:0] r_full;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [2:0]        w_col;
    logic [1:0]        w_full_nxt;
    logic [N*SIZE-1:0] w_bank_vec [2];

    assign in_ready  = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign w_wr_fire = in_valid && in_ready;
    assign w_rd_fire = out_valid && out_ready;
    assign w_col     = in_sof ? 3'd0 : r_wr_col;

    assign out_data = out_valid ? w_bank_vec[r_rd_bank] : '0;
    assign out_row  = r_rd_row;
    assign out_last = out_valid && is_last_idx(r_rd_row);

    dct_tbuf_bank #(
        .SIZE(SIZE)
    ) u_bank0 (
        .clk      (clk),
        .i_wr_en  (w_wr_fire && !r_wr_bank),
        .i_wr_col (w_col),
        .i_wr_vec (in_data),
        .i_rd_row (r_rd_row),
        .o_rd_vec (w_bank_vec[0])
    );

    dct_tbuf_bank #(
        .SIZE(SIZE)
    ) u_bank1 (
        .clk      (clk),
        .i_wr_en  (w_wr_fire && r_wr_bank),
        .i_wr_col (w_col),
        .i_wr_vec (in_data),
        .i_rd_row (r_rd_row),
        .o_rd_vec (w_bank_vec[1])
    );

    // Writer only touches an empty bank and reader only a full one, so both updates never collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && is_last_idx(w_col)) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_fire && is_last_idx(r_rd_row)) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_col  <= 3'd0;
            r_rd_row  <= 3'd0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                if (is_last_idx(w_col)) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_wr_col  <= 3'd0;
                end else begin
                    r_wr_col <= w_col + 3'd1;
                end
            end
            if (w_rd_fire) begin
                if (is_last_idx(r_rd_row)) begin
                    r_rd_bank <= ~r_rd_bank;
                    r_rd_row  <= 3'd0;
                end else begin
                    r_rd_row <= r_rd_row + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench: a queue-of-blocks model predicts handshakes and transposed rows.
module tb_dct_transpose_buf;

    localparam int SIZE = 16;
    localparam int W    = 8 * SIZE;

    typedef logic [64*SIZE-1:0] blk_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_sof;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_row;
    logic         out_last;

    dct_transpose_buf #(
        .SIZE(SIZE),
        .N   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: completed blocks awaiting readout (matrix[r][c] at index r*8+c), plus the block in fill.
    blk_t pend_q[$];
    blk_t cur_blk;
    int   exp_wcol;
    int   exp_rrow;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_out_data();
        logic [W-1:0] v;
        v = '0;
        if (pend_q.size() > 0) begin
            for (int c = 0; c < 8; c++) begin
                v[c*SIZE +: SIZE] = pend_q[0][(exp_rrow*8 + c)*SIZE +: SIZE];
            end
        end
        return v;
    endfunction

    task automatic check_outputs();
        logic ev;
        ev = pend_q.size() > 0;
        chk("in_ready",  W'(in_ready),  W'(pend_q.size() < 2));
        chk("out_valid", W'(out_valid), W'(ev));
        chk("out_row",   W'(out_row),   W'(exp_rrow));
        chk("out_last",  W'(out_last),  W'(ev && exp_rrow == 7));
        chk("out_data",  out_data,      exp_out_data());
    endtask

    // Checks current outputs, drives one cycle of inputs, then advances the model past the edge.
    task automatic cycle(input logic v, input logic sof, input logic [W-1:0] d, input logic ordy);
        logic wfire;
        logic rfire;
        int   col;
        check_outputs();
        in_valid  = v;
        in_sof    = sof;
        in_data   = d;
        out_ready = ordy;
        wfire = v && (pend_q.size() < 2);
        rfire = (pend_q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (rfire) begin
            if (exp_rrow == 7) begin
                void'(pend_q.pop_front());
                exp_rrow = 0;
            end else begin
                exp_rrow++;
            end
        end
        if (wfire) begin
            col = sof ? 0 : exp_wcol;
            for (int r = 0; r < 8; r++) begin
                cur_blk[(r*8 + col)*SIZE +: SIZE] = d[r*SIZE +: SIZE];
            end
            if (col == 7) begin
                pend_q.push_back(cur_blk);
                exp_wcol = 0;
            end else begin
                exp_wcol = col + 1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        pend_q.delete();
        exp_wcol = 0;
        exp_rrow = 0;
        chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_out_data",  out_data,      '0);
        chk("rst_out_row",   W'(out_row),   W'(3'd0));
        chk("rst_out_last",  W'(out_last),  W'(1'b0));
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int r = 0; r < 8; r++) begin
            v[r*SIZE +: SIZE] = SIZE'($urandom);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] ramp_vec(input int k);
        logic [W-1:0] v;
        for (int r = 0; r < 8; r++) begin
            v[r*SIZE +: SIZE] = SIZE'(8*r + k);
        end
        return v;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cur_blk   = '0;
        exp_wcol  = 0;
        exp_rrow  = 0;

        do_reset(2);

        // Single block with the ramp pattern; row r element c must read 8*r+c.
        for (int k = 0; k < 8; k++) cycle(1'b1, k == 0, ramp_vec(k), 1'b1);
        chk("single_valid_after_col7", W'(out_valid), W'(1'b1));
        chk("single_row0", out_data,
            {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0});
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("single_last", W'(out_last), W'(1'b1));
        chk("single_row7", out_data,
            {16'd63, 16'd62, 16'd61, 16'd60, 16'd59, 16'd58, 16'd57, 16'd56});
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Four back-to-back random blocks with the consumer always ready.
        for (int i = 0; i < 32; i++) begin
            chk("stream_in_ready", W'(in_ready), W'(1'b1));
            cycle(1'b1, (i % 8) == 0, rand_vec(), 1'b1);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Backpressure: both banks fill, extra columns are ignored, release frees one bank.
        for (int i = 0; i < 16; i++) cycle(1'b1, (i % 8) == 0, rand_vec(), 1'b0);
        chk("bp_in_ready_low", W'(in_ready), W'(1'b0));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rand_vec(), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("bp_still_full_at_row7", W'(in_ready), W'(1'b0));
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("bp_in_ready_after_row7", W'(in_ready), W'(1'b1));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Resync: three columns, then a new sof restarts the block at column 0.
        for (int i = 0; i < 3; i++) cycle(1'b1, i == 0, rand_vec(), 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, rand_vec(), 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset after five rows have been read, then a fresh block.
        for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, rand_vec(), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        do_reset(1);
        for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, rand_vec(), 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Random traffic with occasional stray sof and irregular consumer.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, rand_vec(), ($urandom % 3) != 0);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
